song_sequencer: RTL and testbench

- Feeds a bank of NUM_VOICES note_player voices from a song ROM.
- Fetches song entries and issues each note to a free voice, with a one-cycle load_new_note pulse.
- Time-advance entries hold off further fetches for a given number of beats.
- Sits between the song ROM and the voice bank, under the top-level play/pause and song-select controls.

---
 rtl/song_pkg.sv | 37 +++
 rtl/song_sequencer_if.sv | 36 +++
 rtl/song_sequencer_voice_allocator.sv | 47 ++++
 rtl/song_sequencer.sv | 170 +++++++++++++++++
 tb/tb_song_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/song_pkg.sv
// song_pkg: song entry layout, end marker and sequencer states.
// Shared by song_sequencer, its interface and the voice allocator.
package song_pkg;

  localparam int ENTRY_BITS = 13;
  localparam int ADV_BIT    = 12;
  localparam int NOTE_MSB   = 11;
  localparam int NOTE_LSB   = 6;
  localparam int DUR_MSB    = 5;
  localparam int DUR_LSB    = 0;

  localparam logic [ENTRY_BITS-1:0] END_MARKER = 13'd0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    DECODE,
    ALLOC,
    ADVANCE,
    NEXT,
    DONE
  } state_t;

  function automatic logic [5:0] entry_note(
    input logic [ENTRY_BITS-1:0] e
  );
    return e[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [5:0] entry_dur(
    input logic [ENTRY_BITS-1:0] e
  );
    return e[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: song ROM port and voice-bank load bus.
// master = sequencer side, slave = ROM / note_player side.
interface song_sequencer_if
  import song_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int SONG_W     = 2,
  parameter int ENTRY_W    = 5
);

  logic [SONG_W+ENTRY_W-1:0] rom_addr;
  logic [ENTRY_BITS-1:0]     rom_data;
  logic [NUM_VOICES-1:0]     done_with_note;
  logic [NUM_VOICES-1:0]     load_new_note;
  logic [6*NUM_VOICES-1:0]   note_to_load;
  logic [6*NUM_VOICES-1:0]   duration_to_load;

  modport master (
    output rom_addr,
    output load_new_note,
    output note_to_load,
    output duration_to_load,
    input  rom_data,
    input  done_with_note
  );

  modport slave (
    input  rom_addr,
    input  load_new_note,
    input  note_to_load,
    input  duration_to_load,
    output rom_data,
    output done_with_note
  );

endinterface

// File: rtl/song_sequencer_voice_allocator.sv
// voice_allocator: combinational lowest-index free-voice picker.
// VOICE_STEAL_EN: fall back to a round-robin pointer when none is free.
module voice_allocator #(
  parameter int NUM_VOICES = 3
`ifdef VOICE_STEAL_EN
  ,
  parameter int PTR_W = 2
`endif
) (
  input  logic [NUM_VOICES-1:0] done,
  input  logic [NUM_VOICES-1:0] busy,
`ifdef VOICE_STEAL_EN
  input  logic [PTR_W-1:0]      ptr,
  output logic                  steal,
`endif
  output logic [NUM_VOICES-1:0] grant,
  output logic                  found
);

  logic [NUM_VOICES-1:0] free;
  logic                  hit;

  assign free = done & ~busy;

  always_comb begin
    grant = '0;
    hit   = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (free[i] && !hit) begin
        grant[i] = 1'b1;
        hit      = 1'b1;
      end
    end
`ifdef VOICE_STEAL_EN
    steal = !hit;
    if (!hit) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (ptr == PTR_W'(i)) grant[i] = 1'b1;
      end
    end
    found = 1'b1;
`else
    found = hit;
`endif
  end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: fetches song ROM entries and issues notes to voices.
// Optional VOICE_STEAL_EN: round-robin voice stealing instead of stalling.
module song_sequencer
  import song_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int SONG_W     = 2,
  parameter int ENTRY_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [SONG_W-1:0] song_select,
  input  logic              beat,
  output logic              song_done,
  song_sequencer_if.master  bus
);

  state_t state_q, state_d;

  logic [SONG_W-1:0]     song_q;
  logic [ENTRY_W-1:0]    index_q;
  logic [5:0]            note_e, dur_e;
  logic [5:0]            cnt_q;
  logic [NUM_VOICES-1:0] busy_q, grant, load;
  logic                  found, restart;
  logic                  is_end, is_adv, adv_zero;
  logic [5:0]            note_q [NUM_VOICES];
  logic [5:0]            dur_q  [NUM_VOICES];

  assign is_end   = bus.rom_data == END_MARKER;
  assign is_adv   = bus.rom_data[ADV_BIT];
  assign adv_zero = entry_dur(bus.rom_data) == '0;

  // Song change mid-play abandons the entry; DONE has its own exit.
  assign restart = play
                && state_q != IDLE
                && state_q != DONE
                && song_select != song_q;

`ifdef VOICE_STEAL_EN
  localparam int PTR_W =
    (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic             steal;

  voice_allocator #(
    .NUM_VOICES(NUM_VOICES),
    .PTR_W     (PTR_W)
  ) u_alloc (
    .done (bus.done_with_note),
    .busy (busy_q),
    .ptr  (ptr_q),
    .steal(steal),
    .grant(grant),
    .found(found)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (steal && |load) begin
      ptr_q <= (ptr_q == PTR_W'(NUM_VOICES-1))
             ? '0 : ptr_q + PTR_W'(1);
    end
  end
`else
  voice_allocator #(
    .NUM_VOICES(NUM_VOICES)
  ) u_alloc (
    .done (bus.done_with_note),
    .busy (busy_q),
    .grant(grant),
    .found(found)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!play) begin
      if (state_q == DONE) state_d = IDLE;
    end else if (restart) begin
      state_d = FETCH;
    end else begin
      unique case (state_q)
        IDLE:     state_d = FETCH;
        FETCH:    state_d = WAIT_ROM;
        WAIT_ROM: state_d = DECODE;
        DECODE: begin
          unique case (1'b1)
            is_end:  state_d = DONE;
            is_adv:  state_d = adv_zero ? NEXT : ADVANCE;
            default: state_d = ALLOC;
          endcase
        end
        ALLOC:   if (found) state_d = NEXT;
        ADVANCE: if (cnt_q == '0) state_d = NEXT;
        NEXT:    state_d = (index_q == '1) ? DONE : FETCH;
        DONE:    if (song_select != song_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    load = '0;
    if (state_q == ALLOC && play && !restart && found) begin
      load = grant;
    end
    song_done = state_q == DONE;
  end

  assign bus.load_new_note = load;
  assign bus.rom_addr      = {song_q, index_q};

  // The pulsing voice sees the new entry in the same cycle as its load.
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    assign bus.note_to_load[6*v +: 6] =
      load[v] ? note_e : note_q[v];
    assign bus.duration_to_load[6*v +: 6] =
      load[v] ? dur_e : dur_q[v];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      song_q  <= '0;
      index_q <= '0;
      note_e  <= '0;
      dur_e   <= '0;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        dur_q[v]  <= '0;
      end
    end else if (play) begin
      busy_q <= load;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (load[v]) begin
          note_q[v] <= note_e;
          dur_q[v]  <= dur_e;
        end
      end
      if (state_q == IDLE || restart) begin
        song_q  <= song_select;
        index_q <= '0;
      end else begin
        case (state_q)
          DECODE: begin
            note_e <= entry_note(bus.rom_data);
            dur_e  <= entry_dur(bus.rom_data);
            cnt_q  <= entry_dur(bus.rom_data);
          end
          ADVANCE: begin
            if (beat && cnt_q != '0) cnt_q <= cnt_q - 6'd1;
          end
          NEXT:    index_q <= index_q + ENTRY_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed table and hand sequences for song_sequencer.
// Build with or without VOICE_STEAL_EN; expectations follow the macro.
`timescale 1ns/1ps
module tb_song_sequencer;
  import song_pkg::*;

  localparam int NV = 3;
  localparam int SW = 2;
  localparam int EW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          play;
  logic          beat;
  logic [SW-1:0] song_select;
  logic          song_done;

  song_sequencer_if #(
    .NUM_VOICES(NV), .SONG_W(SW), .ENTRY_W(EW)
  ) bus ();

  song_sequencer #(
    .NUM_VOICES(NV), .SONG_W(SW), .ENTRY_W(EW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .song_select(song_select),
    .beat       (beat),
    .song_done  (song_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [12:0] rom [128];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  task automatic tick(input logic p, input logic [NV-1:0] d,
                      input logic b, input logic [SW-1:0] s);
    @(negedge clk);
    play = p;
    bus.done_with_note = d;
    beat = b;
    song_select = s;
    #1;
  endtask

  function automatic logic [12:0] ent(int a, int n, int d);
    return {1'(a), 6'(n), 6'(d)};
  endfunction

  function automatic logic [17:0] nd(int a, int b, int c);
    return {6'(c), 6'(b), 6'(a)};
  endfunction

  typedef struct {
    logic [2:0]  d;
    logic        b;
    logic [2:0]  ld;
    logic [6:0]  addr;
    logic [17:0] note;
    logic [17:0] dur;
  } vec_t;

  function automatic vec_t mk(logic [2:0] d, logic b, logic [2:0] ld,
                              logic [6:0] addr, logic [17:0] note,
                              logic [17:0] dur);
    vec_t v;
    v.d = d; v.b = b; v.ld = ld;
    v.addr = addr; v.note = note; v.dur = dur;
    return v;
  endfunction

  vec_t tbl [30];

  initial begin
    logic [17:0] n0, n1, n2, n3, d1, d2, d3;
    int hit, nload;

    for (int i = 0; i < 128; i++) rom[i] = 13'd0;
    rom[0]  = ent(0, 20, 12);
    rom[1]  = ent(0, 21, 13);
    rom[2]  = ent(0, 22, 14);
    rom[3]  = ent(1, 0, 4);
    rom[4]  = ent(0, 23, 15);
    rom[64] = ent(0, 30, 5);
    rom[65] = ent(1, 0, 3);
    rom[66] = ent(0, 31, 6);
    for (int i = 96; i < 128; i++) rom[i] = ent(1, 0, 0);

    n0 = nd(0, 0, 0);
    n1 = nd(20, 0, 0);  d1 = nd(12, 0, 0);
    n2 = nd(20, 21, 0); d2 = nd(12, 13, 0);
    n3 = nd(20, 21, 22); d3 = nd(12, 13, 14);
    tbl[0]  = mk(3'b111, 0, 3'b000, 7'd0, n0, n0);
    tbl[1]  = mk(3'b111, 0, 3'b000, 7'd0, n0, n0);
    tbl[2]  = mk(3'b111, 0, 3'b000, 7'd0, n0, n0);
    tbl[3]  = mk(3'b111, 0, 3'b000, 7'd0, n0, n0);
    tbl[4]  = mk(3'b111, 0, 3'b001, 7'd0, n1, d1);
    tbl[5]  = mk(3'b110, 0, 3'b000, 7'd0, n1, d1);
    tbl[6]  = mk(3'b110, 0, 3'b000, 7'd1, n1, d1);
    tbl[7]  = mk(3'b110, 0, 3'b000, 7'd1, n1, d1);
    tbl[8]  = mk(3'b110, 0, 3'b000, 7'd1, n1, d1);
    tbl[9]  = mk(3'b110, 0, 3'b010, 7'd1, n2, d2);
    tbl[10] = mk(3'b100, 0, 3'b000, 7'd1, n2, d2);
    tbl[11] = mk(3'b100, 0, 3'b000, 7'd2, n2, d2);
    tbl[12] = mk(3'b100, 0, 3'b000, 7'd2, n2, d2);
    tbl[13] = mk(3'b100, 0, 3'b000, 7'd2, n2, d2);
    tbl[14] = mk(3'b100, 0, 3'b100, 7'd2, n3, d3);
    tbl[15] = mk(3'b000, 0, 3'b000, 7'd2, n3, d3);
    tbl[16] = mk(3'b000, 0, 3'b000, 7'd3, n3, d3);
    tbl[17] = mk(3'b000, 0, 3'b000, 7'd3, n3, d3);
    tbl[18] = mk(3'b000, 0, 3'b000, 7'd3, n3, d3);
    tbl[19] = mk(3'b000, 1, 3'b000, 7'd3, n3, d3);
    tbl[20] = mk(3'b000, 0, 3'b000, 7'd3, n3, d3);
    tbl[21] = mk(3'b000, 1, 3'b000, 7'd3, n3, d3);
    tbl[22] = mk(3'b000, 1, 3'b000, 7'd3, n3, d3);
    tbl[23] = mk(3'b000, 0, 3'b000, 7'd3, n3, d3);
    tbl[24] = mk(3'b000, 1, 3'b000, 7'd3, n3, d3);
    tbl[25] = mk(3'b000, 0, 3'b000, 7'd3, n3, d3);
    tbl[26] = mk(3'b000, 0, 3'b000, 7'd3, n3, d3);
    tbl[27] = mk(3'b000, 0, 3'b000, 7'd4, n3, d3);
    tbl[28] = mk(3'b000, 0, 3'b000, 7'd4, n3, d3);
    tbl[29] = mk(3'b000, 0, 3'b000, 7'd4, n3, d3);

    reset = 1'b1;
    play = 1'b0;
    beat = 1'b0;
    song_select = '0;
    bus.done_with_note = '1;
    tick(0, 3'b111, 0, 0);
    tick(0, 3'b111, 0, 0);
    reset = 1'b0;
    tick(0, 3'b111, 0, 0);
    chk("rst load", 32'(bus.load_new_note), 0);
    chk("rst addr", 32'(bus.rom_addr), 0);
    chk("rst done", 32'(song_done), 0);
    chk("rst note", 32'(bus.note_to_load), 0);
    chk("rst dur", 32'(bus.duration_to_load), 0);

    for (int r = 0; r < 30; r++) begin
      tick(1'b1, tbl[r].d, tbl[r].b, 0);
      chk($sformatf("row%0d load", r),
          32'(bus.load_new_note), 32'(tbl[r].ld));
      chk($sformatf("row%0d addr", r),
          32'(bus.rom_addr), 32'(tbl[r].addr));
      chk($sformatf("row%0d done", r), 32'(song_done), 0);
      chk($sformatf("row%0d note", r),
          32'(bus.note_to_load), 32'(tbl[r].note));
      chk($sformatf("row%0d dur", r),
          32'(bus.duration_to_load), 32'(tbl[r].dur));
    end

`ifdef VOICE_STEAL_EN
    tick(1, 3'b000, 0, 0);
    chk("steal load", 32'(bus.load_new_note), 32'h1);
    chk("steal note", 32'(bus.note_to_load), 32'(nd(23, 21, 22)));
    chk("steal dur", 32'(bus.duration_to_load), 32'(nd(15, 13, 14)));
`else
    tick(1, 3'b000, 0, 0);
    chk("stall1 load", 32'(bus.load_new_note), 0);
    tick(1, 3'b000, 0, 0);
    chk("stall2 load", 32'(bus.load_new_note), 0);
    tick(1, 3'b010, 0, 0);
    chk("unstall load", 32'(bus.load_new_note), 32'h2);
    chk("unstall note", 32'(bus.note_to_load), 32'(nd(20, 23, 22)));
    chk("unstall dur", 32'(bus.duration_to_load), 32'(nd(12, 15, 14)));
`endif

    for (int k = 0; k < 4; k++) begin
      tick(1, 3'b111, 0, 0);
      chk($sformatf("pre_end%0d load", k), 32'(bus.load_new_note), 0);
    end
    tick(1, 3'b111, 0, 0);
    chk("end done", 32'(song_done), 1);
    chk("end addr", 32'(bus.rom_addr), 5);
    chk("end load", 32'(bus.load_new_note), 0);

    tick(1, 3'b111, 0, 2);
    chk("sel done", 32'(song_done), 1);
    tick(1, 3'b111, 0, 2);
    chk("sel idle", 32'(song_done), 0);
    tick(1, 3'b111, 0, 2);
    chk("sel addr", 32'(bus.rom_addr), 32'h40);
    tick(1, 3'b111, 0, 2);
    tick(1, 3'b111, 0, 2);
`ifdef VOICE_STEAL_EN
    tick(1, 3'b000, 0, 2);
    chk("s2 load", 32'(bus.load_new_note), 32'h2);
    chk("s2 note", 32'(bus.note_to_load[11:6]), 30);
    chk("s2 dur", 32'(bus.duration_to_load[11:6]), 5);
`else
    tick(1, 3'b001, 0, 2);
    chk("s2 load", 32'(bus.load_new_note), 32'h1);
    chk("s2 note", 32'(bus.note_to_load[5:0]), 30);
    chk("s2 dur", 32'(bus.duration_to_load[5:0]), 5);
`endif
    tick(1, 3'b000, 0, 2);
    tick(1, 3'b000, 0, 2);
    chk("adv fetch", 32'(bus.rom_addr), 32'h41);
    tick(1, 3'b000, 0, 2);
    tick(1, 3'b000, 0, 2);

    for (int k = 0; k < 10; k++) begin
      tick(0, 3'b000, 1, 2);
      chk($sformatf("pause%0d addr", k), 32'(bus.rom_addr), 32'h41);
      chk($sformatf("pause%0d load", k), 32'(bus.load_new_note), 0);
    end
    tick(1, 3'b000, 1, 2);
    chk("res1 addr", 32'(bus.rom_addr), 32'h41);
    tick(1, 3'b000, 0, 2);
    chk("res2 addr", 32'(bus.rom_addr), 32'h41);
    tick(1, 3'b000, 1, 2);
    chk("res3 addr", 32'(bus.rom_addr), 32'h41);
    tick(1, 3'b000, 0, 2);
    chk("res4 addr", 32'(bus.rom_addr), 32'h41);
    tick(1, 3'b000, 0, 2);
    chk("res5 addr", 32'(bus.rom_addr), 32'h41);
    tick(1, 3'b000, 1, 2);
    chk("res6 addr", 32'(bus.rom_addr), 32'h41);
    tick(1, 3'b000, 0, 2);
    chk("res7 addr", 32'(bus.rom_addr), 32'h41);
    tick(1, 3'b000, 0, 2);
    chk("res8 addr", 32'(bus.rom_addr), 32'h41);
    tick(1, 3'b000, 0, 2);
    chk("res fetch", 32'(bus.rom_addr), 32'h42);

    tick(1, 3'b111, 0, 2);
    tick(1, 3'b111, 0, 2);
    tick(1, 3'b111, 0, 2);
    chk("ra load", 32'(bus.load_new_note), 32'h1);
    chk("ra note", 32'(bus.note_to_load[5:0]), 31);
    #2 reset = 1'b1;
    #1;
    chk("async load", 32'(bus.load_new_note), 0);
    chk("async done", 32'(song_done), 0);
    chk("async addr", 32'(bus.rom_addr), 0);
    tick(0, 3'b111, 0, 2);
    reset = 1'b0;
    tick(0, 3'b111, 0, 2);
    chk("post note", 32'(bus.note_to_load), 0);
    chk("post dur", 32'(bus.duration_to_load), 0);
    chk("post addr", 32'(bus.rom_addr), 0);

    tick(1, 3'b111, 0, 0);
    tick(1, 3'b111, 0, 0);
    chk("rs fetch", 32'(bus.rom_addr), 0);
    tick(1, 3'b111, 0, 0);
    tick(1, 3'b111, 0, 0);
    tick(1, 3'b111, 0, 1);
    chk("rs alloc load", 32'(bus.load_new_note), 0);
    tick(1, 3'b111, 0, 1);
    chk("rs addr", 32'(bus.rom_addr), 32'h20);
    chk("rs load", 32'(bus.load_new_note), 0);
    tick(1, 3'b111, 0, 1);
    tick(1, 3'b111, 0, 1);
    tick(1, 3'b111, 0, 1);
    chk("rs end", 32'(song_done), 1);
    tick(0, 3'b111, 0, 1);
    chk("pf done", 32'(song_done), 1);
    tick(0, 3'b111, 0, 1);
    chk("pf idle", 32'(song_done), 0);

    hit = 0;
    nload = 0;
    tick(1, 3'b000, 0, 3);
    for (int n = 1; n <= 200; n++) begin
      tick(1, 3'b000, 0, 3);
      if (bus.load_new_note != '0) nload++;
      if (song_done) begin
        hit = n;
        break;
      end
    end
    chk("wrap cycles", 32'(hit), 129);
    chk("wrap loads", 32'(nload), 0);
    chk("wrap addr", 32'(bus.rom_addr), 32'h60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
